// File: rtl/arbiter_shared_bus.sv
// Two-master round-robin arbiter for a shared Wishbone slave.
// Holds the grant until the owning master drops cyc and guards it with a watchdog timeout.
//
// state | meaning
// IDLE  | no master owns the bus, slave cycle held low
// GNT0  | master 0 owns the bus until it drops cyc
// GNT1  | master 1 owns the bus until it drops cyc
module arbiter_shared_bus #(
  parameter int wb_dat_width = 32,
  parameter int wb_adr_width = 32,
  parameter int wdt_width    = 8
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [wb_adr_width-1:0] wbm0_adr_o,
  input  logic [wb_dat_width-1:0] wbm0_dat_o,
  input  logic [3:0]              wbm0_sel_o,
  input  logic                    wbm0_we_o,
  input  logic                    wbm0_cyc_o,
  input  logic                    wbm0_stb_o,
  input  logic [2:0]              wbm0_cti_o,
  input  logic [1:0]              wbm0_bte_o,
  output logic [wb_dat_width-1:0] wbm0_dat_i,
  output logic                    wbm0_ack_i,
  output logic                    wbm0_err_i,
  output logic                    wbm0_rty_i,
  input  logic [wb_adr_width-1:0] wbm1_adr_o,
  input  logic [wb_dat_width-1:0] wbm1_dat_o,
  input  logic [3:0]              wbm1_sel_o,
  input  logic                    wbm1_we_o,
  input  logic                    wbm1_cyc_o,
  input  logic                    wbm1_stb_o,
  input  logic [2:0]              wbm1_cti_o,
  input  logic [1:0]              wbm1_bte_o,
  output logic [wb_dat_width-1:0] wbm1_dat_i,
  output logic                    wbm1_ack_i,
  output logic                    wbm1_err_i,
  output logic                    wbm1_rty_i,
  output logic [wb_adr_width-1:0] wbs_adr_i,
  output logic [wb_dat_width-1:0] wbs_dat_i,
  output logic [3:0]              wbs_sel_i,
  output logic                    wbs_we_i,
  output logic                    wbs_cyc_i,
  output logic                    wbs_stb_i,
  output logic [2:0]              wbs_cti_i,
  output logic [1:0]              wbs_bte_i,
  input  logic [wb_dat_width-1:0] wbs_dat_o,
  input  logic                    wbs_ack_o,
  input  logic                    wbs_err_o,
  input  logic                    wbs_rty_o,
  output logic [1:0]              arb_gnt_o,
  output logic                    wdt_tmo_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state;
  logic                 lg;
  logic [wdt_width-1:0] wdt_cnt;
  logic                 gnt0, gnt1;
  logic                 m_cyc, m_stb, stb_raw, rsp, wdt_hit;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state     <= IDLE;
      lg        <= 1'b1;
      arb_gnt_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (wbm0_cyc_o && wbm1_cyc_o) begin
            if (lg) begin
              state     <= GNT0;
              arb_gnt_o <= 2'b01;
            end else begin
              state     <= GNT1;
              arb_gnt_o <= 2'b10;
            end
          end else if (wbm0_cyc_o) begin
            state     <= GNT0;
            arb_gnt_o <= 2'b01;
          end else if (wbm1_cyc_o) begin
            state     <= GNT1;
            arb_gnt_o <= 2'b10;
          end
        end
        GNT0: begin
          if (!wbm0_cyc_o) begin
            lg <= 1'b0;
            if (wbm1_cyc_o) begin
              state     <= GNT1;
              arb_gnt_o <= 2'b10;
            end else begin
              state     <= IDLE;
              arb_gnt_o <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!wbm1_cyc_o) begin
            lg <= 1'b1;
            if (wbm0_cyc_o) begin
              state     <= GNT0;
              arb_gnt_o <= 2'b01;
            end else begin
              state     <= IDLE;
              arb_gnt_o <= 2'b00;
            end
          end
        end
        default: begin
          state     <= IDLE;
          arb_gnt_o <= 2'b00;
        end
      endcase
    end
  end

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

  // Cycle qualifiers come straight from the state register so reset drops them without a clock.
  assign m_cyc   = (gnt0 & wbm0_cyc_o) | (gnt1 & wbm1_cyc_o);
  assign m_stb   = gnt1 ? wbm1_stb_o : wbm0_stb_o;
  assign stb_raw = m_cyc & m_stb;
  assign rsp     = wbs_ack_o | wbs_err_o | wbs_rty_o;
  assign wdt_hit = stb_raw & (wdt_cnt == {wdt_width{1'b1}}) & ~rsp;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      wdt_cnt <= '0;
    else if (!stb_raw || rsp || wdt_hit)
      wdt_cnt <= '0;
    else
      wdt_cnt <= wdt_cnt + 1'b1;
  end

  assign wbs_adr_i = gnt1 ? wbm1_adr_o : wbm0_adr_o;
  assign wbs_dat_i = gnt1 ? wbm1_dat_o : wbm0_dat_o;
  assign wbs_sel_i = gnt1 ? wbm1_sel_o : wbm0_sel_o;
  assign wbs_we_i  = gnt1 ? wbm1_we_o  : wbm0_we_o;
  assign wbs_cti_i = gnt1 ? wbm1_cti_o : wbm0_cti_o;
  assign wbs_bte_i = gnt1 ? wbm1_bte_o : wbm0_bte_o;
  assign wbs_cyc_i = m_cyc;
  assign wbs_stb_i = stb_raw & ~wdt_hit;
  assign wdt_tmo_o = wdt_hit;

  assign wbm0_dat_i = wbs_dat_o;
  assign wbm1_dat_i = wbs_dat_o;
  assign wbm0_ack_i = gnt0 & wbs_ack_o;
  assign wbm1_ack_i = gnt1 & wbs_ack_o;
  assign wbm0_err_i = gnt0 & (wbs_err_o | wdt_hit);
  assign wbm1_err_i = gnt1 & (wbs_err_o | wdt_hit);
  assign wbm0_rty_i = gnt0 & wbs_rty_o;
  assign wbm1_rty_i = gnt1 & wbs_rty_o;

endmodule

// File: doc/arbiter_shared_bus.md
ARBITER_SHARED_BUS -- requirements
Module: arbiter_shared_bus

Interface
REQ-001 The block SHALL have parameter wb_dat_width, default 32, data bus width.
REQ-002 The block SHALL have parameter wb_adr_width, default 32, address bus width.
REQ-003 The block SHALL have parameter wdt_width, default 8, watchdog counter width; timeout = 2^wdt_width-1 cycles.
REQ-004 The block SHALL have port wb_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port wb_rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have, for N in {0,1}, inputs from master N: wbmN_adr_o (wb_adr_width), wbmN_dat_o (wb_dat_width), wbmN_sel_o (4), wbmN_we_o (1), wbmN_cyc_o (1), wbmN_stb_o (1), wbmN_cti_o (3), wbmN_bte_o (2).
REQ-007 The block SHALL have, for N in {0,1}, outputs to master N: wbmN_dat_i (wb_dat_width), wbmN_ack_i (1), wbmN_err_i (1), wbmN_rty_i (1).
REQ-008 The block SHALL have slave outputs wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i, with the widths of REQ-006.
REQ-009 The block SHALL have slave inputs wbs_dat_o (wb_dat_width), wbs_ack_o, wbs_err_o, wbs_rty_o (1 each).
REQ-010 The block SHALL have output arb_gnt_o, 2 bits, one-hot current grant (bit N = master N), 00 when idle.
REQ-011 The block SHALL have output wdt_tmo_o, 1 bit, one-cycle pulse on watchdog timeout.

Function
REQ-012 The FSM SHALL have states IDLE, GNT0 and GNT1, with a registered last-granted bit (lg).
REQ-013 In IDLE, a request (wbmN_cyc_o=1) SHALL cause a transition to GNTN on the next edge; if both request, the grant SHALL go to the master not equal to lg.
REQ-014 Latency SHALL be one cycle: the slave sees wbs_cyc_i on the cycle after the grant registers, never combinationally in IDLE.
REQ-015 In GNTN, the state SHALL hold while wbmN_cyc_o=1; no preemption, so burst (cti/bte) and locked cycles complete.
REQ-016 In GNTN with wbmN_cyc_o=0: if the other master requests, the FSM SHALL go directly to GNT(other); otherwise it SHALL go to IDLE; lg<=N in both cases.
REQ-017 In GNTN, all wbs_*_i SHALL equal master N's signals, with wbs_cyc_i/wbs_stb_i gated by the grant; in IDLE, wbs_cyc_i=wbs_stb_i=0 and the other slave outputs SHALL be don't-care (driven from master 0).
REQ-018 wbmN_dat_i SHALL equal wbs_dat_o for both N; ack/err/rty SHALL be routed only to the granted master and forced to 0 for the other master.
REQ-019 The watchdog counter SHALL be 0 when not in GNTx, when wbs_stb_i=0, or in the cycle after any ack/err/rty; otherwise it SHALL increment by 1.
REQ-020 When the counter reaches all-ones: wbmN_err_i=1 for the granted master for exactly one cycle, wdt_tmo_o=1 in that same cycle, wbs_stb_i forced to 0 in that cycle, and the counter cleared on the next edge; the grant SHALL be retained.
REQ-021 If slave ack/err/rty coincides with the timeout cycle, the slave response SHALL win, with no watchdog error and no wdt_tmo_o.
REQ-022 arb_gnt_o SHALL be registered and equal 01 in GNT0, 10 in GNT1 and 00 in IDLE.

Reset
REQ-023 On wb_rst=1, asynchronously: state=IDLE, lg=1 (master 0 wins the first tie), counter=0, arb_gnt_o=00, wdt_tmo_o=0, wbs_cyc_i=wbs_stb_i=0, all wbmN_ack_i/err_i/rty_i=0.
REQ-024 Reset asserted mid-transfer SHALL drop the slave cycle immediately without waiting for a clock; after release, arbitration SHALL restart from IDLE.

Verification
REQ-025 Simultaneous requests from reset: both cyc=1 on the same cycle -> arb_gnt_o=01 one cycle later; after m0 drops cyc with m1 still requesting -> arb_gnt_o=10 on the next edge, with no IDLE cycle.
REQ-026 Round robin: m0 and m1 both hold cyc continuously, each completing one transfer then dropping cyc for 1 cycle -> grant sequence 01,10,01,10, with no master granted twice in a row.
REQ-027 Burst hold: m0 4-beat incrementing burst (cti=010, last beat 111) while m1 requests -> 4 acks to m0 only, m1 ack=0 throughout, grant switches only after m0 drops cyc.
REQ-028 Watchdog: wdt_width=4, slave never acks, m1 granted -> wbm1_err_i and wdt_tmo_o high for exactly one cycle 15 cycles after stb is seen; wbm0_err_i stays 0.
REQ-029 Timeout race: slave ack asserted in exactly the timeout cycle -> ack delivered, err=0, wdt_tmo_o=0.
REQ-030 Async reset mid-read in GNT1 -> wbs_cyc_i, arb_gnt_o and all acks go to 0 before the next clock edge; after release, m1 alone requests -> arb_gnt_o=10 after 1 cycle.
